// File: rtl/inst_encoder.sv
// MIPS-style instruction encoder: encodes requests into a 4-deep FIFO and drains
// them one at a time as instruction-memory writes at an auto-incrementing address.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        cfg_load,
  input  logic [31:0] cfg_addr,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [2:0]  count,
  output logic        busy,
  output logic        err
);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e           state_q;
  logic [3:0][31:0] fifo_q;
  logic [1:0]       head_q, tail_q;
  logic [2:0]       count_q;
  logic [31:0]      wptr_q, addr_q, wdata_q;
  logic             we_q, err_q;

  logic [31:0] enc_d;
  logic        legal_d, accept, push, pop;

  always_comb begin
    enc_d   = 32'd0;
    legal_d = 1'b1;
    case (in_op)
      3'd0:    enc_d = {6'h00, in_rs, in_rt, in_rd, 5'd0, in_funct};
      3'd1:    enc_d = {6'h23, in_rs, in_rt, in_imm};
      3'd2:    enc_d = {6'h2b, in_rs, in_rt, in_imm};
      3'd3:    enc_d = {6'h04, in_rs, in_rt, in_imm};
      3'd4:    enc_d = {6'h02, in_target};
      default: legal_d = 1'b0;
    endcase
  end

  assign in_ready = (count_q != 3'd4);
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal_d;
  // mem_ack only counts while a write is outstanding
  assign pop      = (state_q == WRITE) && mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fifo_q  <= '0;
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
      wptr_q  <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[tail_q] <= enc_d;
        tail_q         <= tail_q + 2'd1;
      end
      if (accept && !legal_d) err_q <= 1'b1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};

      case (state_q)
        IDLE: begin
          if (count_q != 3'd0) begin
            state_q <= WRITE;
            we_q    <= 1'b1;
            addr_q  <= wptr_q;
            wdata_q <= fifo_q[head_q];
          end else if (cfg_load && !push) begin
            wptr_q <= {cfg_addr[31:2], 2'b00};
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            wptr_q  <= wptr_q + 32'd4;
            head_q  <= head_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign busy      = (state_q == WRITE) || (count_q != 3'd0);
  assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: expected writes are queued at acceptance
// and checked in order as the encoder raises mem_we.
module tb_inst_encoder;

  logic        clk, rst_n, in_valid, in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        cfg_load;
  logic [31:0] cfg_addr;
  logic        mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  count;
  logic        busy, err;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .cfg_load(cfg_load), .cfg_addr(cfg_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count), .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         q[$];
  wr_t         cur;
  logic        seen;
  logic        ack_en;
  logic [31:0] next_addr;
  int          n_checks, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory side: acknowledge one cycle after a write appears
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = ack_en && mem_we;
    end
  end

  // scoreboard: every new write must match the oldest queued expectation
  initial begin
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 1'b0;
      else if (mem_we && !seen) begin
        seen = 1'b1;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: addr=%h data=%h, none expected", mem_addr, mem_wdata);
          cur = '{addr: mem_addr, data: mem_wdata};
        end else begin
          cur = q.pop_front();
          if (mem_addr !== cur.addr || mem_wdata !== cur.data) begin
            n_fail++;
            $display("FAIL write_order: got addr=%h data=%h, want addr=%h data=%h",
                     mem_addr, mem_wdata, cur.addr, cur.data);
          end
        end
      end else if (mem_we && seen) begin
        n_checks++;
        if (mem_addr !== cur.addr || mem_wdata !== cur.data) begin
          n_fail++;
          $display("FAIL write_stable: got addr=%h data=%h, want addr=%h data=%h",
                   mem_addr, mem_wdata, cur.addr, cur.data);
        end
      end else seen = 1'b0;
    end
  end

  task automatic send(input [2:0] op, input [4:0] rs, input [4:0] rt, input [4:0] rd,
                      input [5:0] funct, input [15:0] imm, input [25:0] target,
                      input [31:0] exp_data);
    int n;
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = funct; in_imm = imm; in_target = target;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end else begin
      @(posedge clk);
      if (op < 3'd5) begin
        q.push_back('{addr: next_addr, data: exp_data});
        next_addr = next_addr + 32'd4;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic load_base(input [31:0] a);
    cfg_load = 1'b1; cfg_addr = a;
    @(posedge clk);
    #1 cfg_load = 1'b0;
    next_addr = {a[31:2], 2'b00};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    n_checks++;
    if (busy !== 1'b0 || q.size() != 0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain: busy=%b count=%0d pending=%0d, want 0/0/0", busy, count, q.size());
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    next_addr = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_funct = '0; in_imm = '0; in_target = '0; cfg_load = 1'b0; cfg_addr = '0;
    ack_en = 1'b1; next_addr = 32'd0; n_checks = 0; n_fail = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, mem_we, busy, err, count} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_ctl: ready=%b we=%b busy=%b err=%b count=%0d, want 1 0 0 0 0",
               in_ready, mem_we, busy, err, count);
    end
    n_checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h data=%h, want 0/0", mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1 n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_basic_lw();
    load_base(32'h0040_0000);
    send(3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0004, 26'd0, 32'h8D09_0004);
    n_checks++;
    if (mem_we !== 1'b0 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL lw_accept: we=%b count=%0d, want 0/1", mem_we, count);
    end
    @(posedge clk);
    #1 n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0040_0000 || mem_wdata !== 32'h8D09_0004) begin
      n_fail++;
      $display("FAIL lw_latency: we=%b addr=%h data=%h, want 1 00400000 8d090004",
               mem_we, mem_addr, mem_wdata);
    end
    wait_idle();
    // next write must land at the advanced pointer 0x00400004
    send(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0001, 32'h0800_0001);
    wait_idle();
  endtask

  task automatic test_encodings();
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 32'h0022_1820);
    send(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000, 32'h0810_0000);
    send(3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFF, 26'd0, 32'h1085_FFFF);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [4:0]  rs, rt;
      logic [15:0] imm;
      rs = 5'(i + 1); rt = 5'(i + 10); imm = 16'(16'h0100 + i);
      send(3'd2, rs, rt, 5'd0, 6'd0, imm, 26'd0, {6'h2b, rs, rt, imm});
      if (i == 2) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready3: in_ready=%b, want 1", in_ready);
        end
      end
    end
    n_checks++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_full: in_ready=%b count=%0d, want 0/4", in_ready, count);
    end
    // fifth request and a base reload both held while full: neither may take effect
    in_valid = 1'b1; in_op = 3'd2; in_rs = 5'd5; in_rt = 5'd14; in_imm = 16'h0104;
    cfg_load = 1'b1; cfg_addr = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 n_checks++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold: count=%0d in_ready=%b, want 4/0", count, in_ready);
      end
    end
    cfg_load = 1'b0; in_valid = 1'b0;
    ack_en = 1'b1;
    send(3'd2, 5'd5, 5'd14, 5'd0, 6'd0, 16'h0104, 26'd0, {6'h2b, 5'd5, 5'd14, 16'h0104});
    wait_idle();
  endtask

  task automatic test_illegal();
    send(3'd6, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'd1, 32'd0);
    n_checks++;
    if (err !== 1'b1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL illegal_flag: err=%b count=%0d, want 1/0", err, count);
    end
    repeat (4) @(posedge clk);
    #1 n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_nowrite: we=%b busy=%b, want 0/0", mem_we, busy);
    end
    send(3'd0, 5'd7, 5'd8, 5'd9, 6'h22, 16'd0, 26'd0, {6'h00, 5'd7, 5'd8, 5'd9, 5'd0, 6'h22});
    wait_idle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_sticky: err=%b, want 1", err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset: err=%b, want 0", err);
    end
    load_base(32'hFFFF_FFFF);
    send(3'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h00AA, 26'd0, {6'h23, 5'd2, 5'd3, 16'h00AA});
    send(3'd2, 5'd4, 5'd6, 5'd0, 6'd0, 16'h8000, 26'd0, {6'h2b, 5'd4, 5'd6, 16'h8000});
    wait_idle();
  endtask

  task automatic test_reset_mid_write();
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++)
      send(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'(i + 1), {6'h02, 26'(i + 1)});
    n_checks++;
    if (mem_we !== 1'b1 || count !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_setup: we=%b count=%0d, want 1/3", mem_we, count);
    end
    #2 rst_n = 1'b0;
    q.delete();
    #1 n_checks++;
    if (mem_we !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: we=%b count=%0d ready=%b, want 0/0/1", mem_we, count, in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (10) @(posedge clk);
    #1 n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_after: we=%b busy=%b count=%0d, want 0/0/0", mem_we, busy, count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_lw();
    test_encodings();
    test_back_to_back();
    test_illegal();
    test_wrap();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
